// File: rtl/mb_record_writer.sv
// mb_record_writer: drains the macroblock encoder output FIFO (7 wide beats
// per macroblock), re-emits every beat as a low word then a high word on a
// valid/ready stream, marks macroblock/frame ends and accumulates per-frame
// skip count and maximum edge from the metadata beat.
module mb_record_writer #(
  parameter int IN_W         = 1024,
  parameter int OUT_W        = 512,
  parameter int BEATS_PER_MB = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [19:0]        mb_total,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [IN_W-1:0]    fifo_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_mb_last,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic [19:0]        mb_count,
  output logic [19:0]        skip_count,
  output logic [31:0]        frame_max_edge
);

  localparam int BEAT_W   = $clog2(BEATS_PER_MB);
  // Metadata beat fields used for statistics.
  localparam int SKIP_BIT = 904;
  localparam int EDGE_LSB = 928;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_LO, S_HI, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [19:0]         mb_total_q;
  logic [BEAT_W-1:0]   beat;
  logic [IN_W-1:0]     hold;
  logic                last_beat, last_mb;
  logic [31:0]         meta_edge;

  assign last_beat = (beat == BEAT_W'(BEATS_PER_MB - 1));
  assign last_mb   = (mb_count == mb_total_q - 20'd1);
  assign meta_edge = hold[EDGE_LSB +: 32];

  // State register, hold register, beat counter and frame statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mb_total_q     <= '0;
      beat           <= '0;
      hold           <= '0;
      mb_count       <= '0;
      skip_count     <= '0;
      frame_max_edge <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          mb_total_q     <= mb_total;
          beat           <= '0;
          mb_count       <= '0;
          skip_count     <= '0;
          frame_max_edge <= '0;
        end
        S_CAP: hold <= fifo_dout;
        S_HI: if (m_ready) begin
          if (last_beat) begin
            beat     <= '0;
            mb_count <= mb_count + 20'd1;
            if (hold[SKIP_BIT]) skip_count <= skip_count + 20'd1;
            if (meta_edge > frame_max_edge) frame_max_edge <= meta_edge;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all stream/FIFO strobes, decoded from the state register.
  always_comb begin
    state_d   = state_q;
    fifo_rd   = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_mb_last = 1'b0;
    m_last    = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = (mb_total == 20'd0) ? S_DONE : S_RD;
      S_RD: begin
        fifo_rd = !fifo_empty;
        if (!fifo_empty) state_d = S_CAP;
      end
      S_CAP: state_d = S_LO;
      S_LO: begin
        m_valid = 1'b1;
        m_data  = hold[OUT_W-1:0];
        if (m_ready) state_d = S_HI;
      end
      S_HI: begin
        m_valid   = 1'b1;
        m_data    = hold[IN_W-1:OUT_W];
        m_mb_last = last_beat;
        m_last    = last_beat && last_mb;
        if (m_ready) state_d = (last_beat && last_mb) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mb_record_writer.sv
// Bench for mb_record_writer: a FIFO model feeds beats, the stimulus pushes
// expected output words into a scoreboard queue and an independent monitor
// pops and compares on every handshake.
module tb_mb_record_writer;

  typedef struct packed {
    logic [511:0] d;
    logic         ml;
    logic         l;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [19:0]    mb_total = '0;
  logic           fifo_empty;
  logic           fifo_rd;
  logic [1023:0]  fifo_dout = '0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [511:0]   m_data;
  logic           m_mb_last, m_last, busy, done;
  logic [19:0]    mb_count, skip_count;
  logic [31:0]    frame_max_edge;

  mb_record_writer dut (
    .clk(clk), .rst(rst), .start(start), .mb_total(mb_total),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_mb_last(m_mb_last), .m_last(m_last), .busy(busy), .done(done),
    .mb_count(mb_count), .skip_count(skip_count), .frame_max_edge(frame_max_edge)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  logic [1023:0] mem [0:127];
  int wr_ptr = 0, rd_ptr = 0, rd_cnt = 0;
  logic starve = 1'b0;
  assign fifo_empty = starve || (rd_ptr == wr_ptr);
  always @(posedge clk) if (fifo_rd) begin
    fifo_dout <= mem[rd_ptr % 128];
    rd_ptr    <= rd_ptr + 1;
    rd_cnt    <= rd_cnt + 1;
  end

  // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
  int ready_mode = 0, rcnt = 0;
  always @(posedge clk) begin
    #1;
    rcnt = rcnt + 1;
    m_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 4 == 0) || (rcnt % 4 == 3));
  end

  exp_t exp_q[$];
  int tests = 0, fails = 0;
  int mtests = 0, mfails = 0;
  int words = 0;

  // Monitor: scoreboard pop on handshake, stall stability, no reads while starved.
  logic         stalled = 1'b0;
  logic [511:0] st_d;
  logic         st_ml, st_l;
  always @(negedge clk) begin
    if (rst) stalled = 1'b0;
    else begin
      if (stalled) begin
        mtests++;
        if (!m_valid || m_data !== st_d || m_mb_last !== st_ml || m_last !== st_l) begin
          mfails++;
          $display("FAIL stall_stable: valid=%0b data=%h ml=%0b l=%0b, required held data=%h ml=%0b l=%0b",
                   m_valid, m_data[31:0], m_mb_last, m_last, st_d[31:0], st_ml, st_l);
        end
      end
      if (m_valid && m_ready) begin
        exp_t e;
        mtests++;
        words++;
        if (exp_q.size() == 0) begin
          mfails++;
          $display("FAIL extra_word: got data=%h with empty scoreboard", m_data[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_mb_last !== e.ml || m_last !== e.l) begin
            mfails++;
            $display("FAIL word%0d: data=%h ml=%0b l=%0b, required data=%h ml=%0b l=%0b",
                     words, m_data[31:0], m_mb_last, m_last, e.d[31:0], e.ml, e.l);
          end
        end
      end
      if (starve && fifo_rd) begin
        mtests++;
        mfails++;
        $display("FAIL starve_rd: fifo_rd=1 while FIFO empty");
      end
      stalled = m_valid && !m_ready;
      st_d = m_data; st_ml = m_mb_last; st_l = m_last;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [1023:0] mk_beat(input int pat, input int m, input int k,
                                            input logic sk, input logic [31:0] e);
    logic [1023:0] b;
    logic [511:0]  w;
    if (pat == 1) begin
      w = 512'(k) + 512'h10;
      b = {w, w};
    end else if (k < 6) begin
      b = {{16{32'h2000_0002 + 32'(m * 256 + k * 16)}},
           {16{32'h1000_0001 + 32'(m * 256 + k * 16)}}};
    end else begin
      b = '0;
      b[255:0]     = {8{32'hDC00_0000 + 32'(m)}};
      b[903:896]   = 8'h03;
      b[904]       = sk;
      b[959:928]   = e;
    end
    return b;
  endfunction

  // Queue one macroblock in the FIFO and its 14 expected words in the scoreboard.
  task automatic load_mb(input int pat, input int m, input int total,
                         input logic sk, input logic [31:0] e);
    logic [1023:0] b;
    exp_t x;
    for (int k = 0; k < 7; k++) begin
      b = mk_beat(pat, m, k, sk, e);
      mem[wr_ptr % 128] = b;
      wr_ptr = wr_ptr + 1;
      x.d = b[511:0];    x.ml = 1'b0; x.l = 1'b0;
      exp_q.push_back(x);
      x.d = b[1023:512]; x.ml = (k == 6); x.l = (k == 6) && (m == total - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1; mb_total = 20'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (done) break;
      @(negedge clk);
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, bound);
    end
  endtask

  task automatic wait_rd(input int target, input int bound);
    int i;
    for (i = 0; i < bound && rd_cnt < target; i++) @(negedge clk);
    check("rd_reached", (rd_cnt >= target), 1);
  endtask

  task automatic frame_end(input string name, input int mbs, input int sk, input logic [31:0] e);
    check({name, "_mb_count"}, 32'(mb_count), mbs);
    check({name, "_skip_count"}, 32'(skip_count), sk);
    check({name, "_max_edge"}, frame_max_edge, e);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 0);
    check({name, "_idle"}, 32'(busy), 0);
    check({name, "_scoreboard_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    logic rd_seen, done_seen;
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    check("rst_data", m_data[31:0], 0);
    check("rst_counts", 32'(mb_count) | 32'(skip_count) | frame_max_edge, 0);
    rst = 1'b0;

    // Single macroblock.
    load_mb(1, 0, 1, 1'b0, 32'h0);
    pulse_start(1);
    wait_done("single", 200);
    frame_end("single", 1, 0, 32'h0);

    // Backpressure, two macroblocks.
    ready_mode = 1;
    load_mb(0, 0, 2, 1'b0, 32'h7);
    load_mb(0, 1, 2, 1'b0, 32'h3);
    pulse_start(2);
    wait_done("bp", 1000);
    frame_end("bp", 2, 0, 32'h7);
    ready_mode = 0;

    // FIFO starvation before beat 3.
    base = rd_cnt;
    load_mb(0, 0, 1, 1'b1, 32'h9);
    pulse_start(1);
    wait_rd(base + 3, 200);
    starve = 1'b1;
    repeat (10) @(negedge clk);
    check("starve_busy", 32'(busy), 1);
    check("starve_no_valid", 32'(m_valid), 0);
    starve = 1'b0;
    wait_done("starve", 300);
    frame_end("starve", 1, 1, 32'h9);

    // Statistics, with an ignored start mid-frame.
    base = rd_cnt;
    load_mb(0, 0, 3, 1'b1, 32'h10);
    load_mb(0, 1, 3, 1'b0, 32'hFFFF_0000);
    load_mb(0, 2, 3, 1'b1, 32'h20);
    pulse_start(3);
    wait_rd(base + 2, 200);
    pulse_start(5);
    wait_done("stats", 1000);
    frame_end("stats", 3, 2, 32'hFFFF_0000);

    // Zero-length frame.
    rd_seen = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; mb_total = 20'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (fifo_rd) rd_seen = 1'b1;
      if (done && i == 0) done_seen = 1'b1;
    end
    check("zero_done", 32'(done_seen), 1);
    check("zero_no_rd", 32'(rd_seen), 0);
    check("zero_mb_count", 32'(mb_count), 0);

    // Reset during beat 4 of macroblock 0.
    base = rd_cnt;
    load_mb(0, 0, 2, 1'b1, 32'h44);
    load_mb(0, 1, 2, 1'b1, 32'h45);
    pulse_start(2);
    wait_rd(base + 5, 300);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_busy_done", 32'(busy) | 32'(done) | 32'(fifo_rd), 0);
    check("mid_rst_flags", 32'(m_mb_last) | 32'(m_last), 0);
    check("mid_rst_data", m_data[31:0] | m_data[511:480], 0);
    check("mid_rst_counts", 32'(mb_count) | 32'(skip_count) | frame_max_edge, 0);
    exp_q.delete();
    wr_ptr = rd_ptr;
    rst = 1'b0;
    load_mb(0, 0, 1, 1'b1, 32'h55);
    pulse_start(1);
    wait_done("after_rst", 300);
    frame_end("after_rst", 1, 1, 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests + mtests, fails + mfails);
    $finish;
  end

endmodule
